// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_fetch_unit                                                |
// | Description : Instruction-fetch stage and producer side of the IF/ID       |
// |               pipeline register. Owns the PC, issues req/ack fetches to    |
// |               instruction memory, delivers {PC+4, instruction} pairs,      |
// |               honours hazard stalls and handles branch/jump redirects,     |
// |               including discarding a fetch already in flight.              |
// | Ports       : clk, reset (async, active-low)                               |
// |               stall, redirect_valid, redirect_pc      - pipeline control   |
// |               imem_req, imem_addr, imem_ack, imem_rdata - memory port      |
// |               out_valid, out_PC_4, out_Instruction     - to IF/ID register |
// |               fetch_count (only with IF_FETCH_COUNT_EN) - delivery counter |
// | Options     : `define IF_FETCH_COUNT_EN adds the fetch_count output.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module if_fetch_unit #(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] RESET_PC = 'h0040_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [NBits-1:0] redirect_pc,
    output logic             imem_req,
    output logic [NBits-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [NBits-1:0] imem_rdata,
    output logic             out_valid,
    output logic [NBits-1:0] out_PC_4,
    output logic [NBits-1:0] out_Instruction
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0]      fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding at r_pc
        S_HOLD  = 2'd1,   // response buffered while stalled
        S_KILL  = 2'd2    // outstanding response at r_kill_addr to be dropped
    } state_t;

    state_t           r_state;
    logic [NBits-1:0] r_pc;
    logic [NBits-1:0] r_kill_addr;
    logic [NBits-1:0] r_buf;
    logic             r_out_valid;
    logic [NBits-1:0] r_out_pc4;
    logic [NBits-1:0] r_out_instr;

    state_t           w_state_n;
    logic [NBits-1:0] w_pc_n;
    logic [NBits-1:0] w_kill_addr_n;
    logic [NBits-1:0] w_buf_n;
    logic             w_out_valid_n;
    logic [NBits-1:0] w_out_pc4_n;
    logic [NBits-1:0] w_out_instr_n;
    logic             w_deliver;
    logic [NBits-1:0] w_pc_plus4;
    logic [NBits-1:0] w_redirect_target;

    // Wraps naturally modulo 2^NBits.
    assign w_pc_plus4        = r_pc + NBits'(4);
    // Low two bits are forced to zero so targets are always word aligned.
    assign w_redirect_target = redirect_pc & ~NBits'(3);

    // After a redirect the memory still owes a response for the old address,
    // so the request keeps presenting that address until it is acknowledged.
    assign imem_req  = (r_state != S_HOLD);
    assign imem_addr = (r_state == S_KILL) ? r_kill_addr : r_pc;

    assign out_valid       = r_out_valid;
    assign out_PC_4        = r_out_pc4;
    assign out_Instruction = r_out_instr;

    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_kill_addr_n = r_kill_addr;
        w_buf_n       = r_buf;
        w_out_valid_n = r_out_valid;
        w_out_pc4_n   = r_out_pc4;
        w_out_instr_n = r_out_instr;
        w_deliver     = 1'b0;

        if (redirect_valid) begin
            // Redirect outranks stall and ack: flush, keep out_PC_4.
            w_pc_n        = w_redirect_target;
            w_out_valid_n = 1'b0;
            w_out_instr_n = '0;
            case (r_state)
                S_FETCH: begin
                    if (!imem_ack) begin
                        w_state_n     = S_KILL;
                        w_kill_addr_n = r_pc;
                    end
                end
                S_HOLD:  w_state_n = S_FETCH;
                default: w_state_n = S_KILL;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (stall) begin
                        if (imem_ack) begin
                            w_buf_n   = imem_rdata;
                            w_state_n = S_HOLD;
                        end
                    end else if (imem_ack) begin
                        w_out_instr_n = imem_rdata;
                        w_out_pc4_n   = w_pc_plus4;
                        w_out_valid_n = 1'b1;
                        w_pc_n        = w_pc_plus4;
                        w_deliver     = 1'b1;
                    end else begin
                        w_out_valid_n = 1'b0;
                        w_out_instr_n = '0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_out_instr_n = r_buf;
                        w_out_pc4_n   = w_pc_plus4;
                        w_out_valid_n = 1'b1;
                        w_pc_n        = w_pc_plus4;
                        w_deliver     = 1'b1;
                        w_state_n     = S_FETCH;
                    end
                end
                default: begin
                    if (imem_ack) begin
                        w_out_valid_n = 1'b0;
                        w_out_instr_n = '0;
                        w_state_n     = S_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_kill_addr <= RESET_PC;
            r_buf       <= '0;
            r_out_valid <= 1'b0;
            r_out_pc4   <= '0;
            r_out_instr <= '0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_kill_addr <= w_kill_addr_n;
            r_buf       <= w_buf_n;
            r_out_valid <= w_out_valid_n;
            r_out_pc4   <= w_out_pc4_n;
            r_out_instr <= w_out_instr_n;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // Counts real deliveries only; a stalled valid output is not re-counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
        end else if (w_deliver) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    logic w_unused_deliver;
    assign w_unused_deliver = w_deliver;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_fetch_unit                                             |
// | Description : Directed self-checking bench for if_fetch_unit. Each task    |
// |               drives one scenario and checks hand-computed values.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_PC_4;
    logic [31:0] out_Instruction;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks;
    int errors;

    if_fetch_unit #(.NBits(32), .RESET_PC(32'h0040_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_PC_4        (out_PC_4),
        .out_Instruction (out_Instruction)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h expected 0", out_valid); end
        checks++; if (out_PC_4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 00000000", out_PC_4); end
        checks++; if (out_Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", out_Instruction); end
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_addr: got %h expected 00400000", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %h expected 1", imem_req); end
`ifdef IF_FETCH_COUNT_EN
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
`endif
        reset = 1'b1;
    endtask

    // Zero-wait memory: rdata = PC ^ A5A5_0000.
    task automatic test_stream();
        logic [31:0] exp_pc4   [3] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
        logic [31:0] exp_instr [3] = '{32'hA5E5_0000, 32'hA5E5_0004, 32'hA5E5_0008};
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ 32'hA5A5_0000;
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %h expected 1", i, out_valid); end
            checks++; if (out_PC_4 !== exp_pc4[i]) begin errors++; $display("FAIL stream_pc4[%0d]: got %h expected %h", i, out_PC_4, exp_pc4[i]); end
            checks++; if (out_Instruction !== exp_instr[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, out_Instruction, exp_instr[i]); end
        end
        imem_ack = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_Instruction !== 32'h0) begin errors++; $display("FAIL stream_bubble: got valid=%h instr=%h expected 0/0", out_valid, out_Instruction); end
        checks++; if (imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL stream_addr: got %h expected 0040000c", imem_addr); end
    endtask

    task automatic test_delayed_ack();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'h0040_000C || imem_req !== 1'b1) begin errors++; $display("FAIL delay_addr[%0d]: got req=%h addr=%h expected 1/0040000c", i, imem_req, imem_addr); end
            checks++; if (out_valid !== 1'b0 || out_Instruction !== 32'h0) begin errors++; $display("FAIL delay_bubble[%0d]: got valid=%h instr=%h expected 0/0", i, out_valid, out_Instruction); end
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_PC_4 !== 32'h0040_0010 || out_Instruction !== 32'h1234_5678) begin errors++; $display("FAIL delay_deliver: got valid=%h pc4=%h instr=%h expected 1/00400010/12345678", out_valid, out_PC_4, out_Instruction); end
    endtask

    task automatic test_stall_hold();
        // Deliver one word first so the frozen outputs are a valid instruction.
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        step();
        checks++; if (out_PC_4 !== 32'h0040_0014 || out_Instruction !== 32'hCAFE_0001) begin errors++; $display("FAIL hold_pre: got pc4=%h instr=%h expected 00400014/cafe0001", out_PC_4, out_Instruction); end
        stall      = 1'b1;
        imem_rdata = 32'hBEEF_0002;
        for (int i = 0; i < 4; i++) begin
            step();
            imem_ack = 1'b0;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %h expected 0", i, imem_req); end
            checks++; if (out_valid !== 1'b1 || out_PC_4 !== 32'h0040_0014 || out_Instruction !== 32'hCAFE_0001) begin errors++; $display("FAIL hold_frozen[%0d]: got valid=%h pc4=%h instr=%h expected 1/00400014/cafe0001", i, out_valid, out_PC_4, out_Instruction); end
        end
        stall = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_PC_4 !== 32'h0040_0018 || out_Instruction !== 32'hBEEF_0002) begin errors++; $display("FAIL hold_release: got valid=%h pc4=%h instr=%h expected 1/00400018/beef0002", out_valid, out_PC_4, out_Instruction); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0018) begin errors++; $display("FAIL hold_next_addr: got req=%h addr=%h expected 1/00400018", imem_req, imem_addr); end
        step();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0040_0018) begin errors++; $display("FAIL hold_once: got valid=%h addr=%h expected 0/00400018", out_valid, imem_addr); end
    endtask

    task automatic test_redirect_kill();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        imem_ack       = 1'b0;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_Instruction !== 32'h0 || out_PC_4 !== 32'h0040_0018) begin errors++; $display("FAIL kill_flush: got valid=%h instr=%h pc4=%h expected 0/0/00400018", out_valid, out_Instruction, out_PC_4); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0018) begin errors++; $display("FAIL kill_old_addr[%0d]: got req=%h addr=%h expected 1/00400018", i, imem_req, imem_addr); end
            if (i < 2) step();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_DEAD;
        step();
        checks++; if (out_valid !== 1'b0 || out_Instruction !== 32'h0) begin errors++; $display("FAIL kill_discard: got valid=%h instr=%h expected 0/0", out_valid, out_Instruction); end
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL kill_new_addr: got %h expected 00400100", imem_addr); end
        imem_rdata = 32'h0000_0AAA;
        step();
        checks++; if (out_valid !== 1'b1 || out_PC_4 !== 32'h0040_0104 || out_Instruction !== 32'h0000_0AAA) begin errors++; $display("FAIL kill_refetch: got valid=%h pc4=%h instr=%h expected 1/00400104/00000aaa", out_valid, out_PC_4, out_Instruction); end
    endtask

    task automatic test_redirect_stall_ack();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        stall          = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h7777_7777;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_Instruction !== 32'h0 || out_PC_4 !== 32'h0040_0104) begin errors++; $display("FAIL rsa_flush: got valid=%h instr=%h pc4=%h expected 0/0/00400104", out_valid, out_Instruction, out_PC_4); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL rsa_addr: got req=%h addr=%h expected 1/00400200", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        // Ack on the redirect cycle discards the word and stays in FETCH.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h5555_5555;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_target: got addr=%h valid=%h expected fffffffc/0", imem_addr, out_valid); end
        imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_PC_4 !== 32'h0 || out_Instruction !== 32'h0000_0013) begin errors++; $display("FAIL wrap_pc4: got valid=%h pc4=%h instr=%h expected 1/00000000/00000013", out_valid, out_PC_4, out_Instruction); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
`ifdef IF_FETCH_COUNT_EN
        // 3 stream + 1 delayed + 2 stall/hold + 1 refetch + 1 wrap.
        checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL fetch_count: got %0d expected 8", fetch_count); end
`endif
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        test_reset();
        test_stream();
        test_delayed_ack();
        test_stall_hold();
        test_redirect_kill();
        test_redirect_stall_ack();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
